// File: rtl/counter_share_arbiter.sv
// Shares one up-counter between two requesters with round-robin arbitration.
// A granted run counts q from 0 to the latched terminal value, then pulses done.
//
// state | meaning
// IDLE  | no owner; samples req and grants the winner
// RUN   | counter advancing toward latched terminal value
// DONE  | one-cycle completion pulse to the owner
module counter_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic             owner;
  logic             last;
  logic [WIDTH-1:0] len_l;

  logic             win;
  logic [1:0]       win_oh;
  logic [WIDTH-1:0] win_len;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win     = (req == 2'b11) ? ~last : req[1];
    win_oh  = win ? 2'b10 : 2'b01;
    win_len = win ? len1 : len0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      gnt   <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
      q     <= '0;
      last  <= 1'b1;
      owner <= 1'b0;
      len_l <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_RUN;
            owner <= win;
            gnt   <= win_oh;
            q     <= '0;
            len_l <= win_len;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          // An owner dropping its request abandons the run without a done pulse.
          if (!req[owner]) begin
            state <= S_IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            last  <= owner;
          end else if (q == len_l) begin
            state <= S_DONE;
            gnt   <= 2'b00;
            done  <= gnt;
          end else begin
            q <= q + ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 2'b00;
          busy  <= 1'b0;
          last  <= owner;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 2'b00;
          done  <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed bench for counter_share_arbiter: reset, single run, round robin,
// terminal-value boundaries, cancel and reset mid-run.
module tb_counter_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  counter_share_arbiter #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs as one packed word {gnt, done, busy, q}.
  task automatic chk_all(input string tag, input logic [1:0] eg, input logic [1:0] ed,
                         input logic eb, input logic [3:0] eq);
    chk(tag, {23'd0, gnt, done, busy, q}, {23'd0, eg, ed, eb, eq});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    len0  = 4'd0;
    len1  = 4'd0;

    // T1 reset held with both requesting
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("t1_reset", 2'b00, 2'b00, 1'b0, 4'd0);
    end

    // T2 single request, len0=3
    req   = 2'b00;
    rst_n = 1'b1;
    step();
    chk_all("t2_idle", 2'b00, 2'b00, 1'b0, 4'd0);
    req  = 2'b01;
    len0 = 4'd3;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all("t2_run", 2'b01, 2'b00, 1'b1, 4'(k));
    end
    step();
    chk_all("t2_done", 2'b00, 2'b01, 1'b1, 4'd3);
    req = 2'b00;
    step();
    chk_all("t2_back_idle", 2'b00, 2'b00, 1'b0, 4'd3);

    // T3 round robin after reset, req=11 held
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 2'b11;
    len0  = 4'd1;
    len1  = 4'd2;
    step();
    chk_all("t3_g0_q0", 2'b01, 2'b00, 1'b1, 4'd0);
    step();
    chk_all("t3_g0_q1", 2'b01, 2'b00, 1'b1, 4'd1);
    step();
    chk_all("t3_done0", 2'b00, 2'b01, 1'b1, 4'd1);
    step();
    chk_all("t3_idle0", 2'b00, 2'b00, 1'b0, 4'd1);
    step();
    chk_all("t3_g1_q0", 2'b10, 2'b00, 1'b1, 4'd0);
    step();
    chk_all("t3_g1_q1", 2'b10, 2'b00, 1'b1, 4'd1);
    step();
    chk_all("t3_g1_q2", 2'b10, 2'b00, 1'b1, 4'd2);
    step();
    chk_all("t3_done1", 2'b00, 2'b10, 1'b1, 4'd2);
    step();
    chk_all("t3_idle1", 2'b00, 2'b00, 1'b0, 4'd2);
    step();
    chk_all("t3_g0_again", 2'b01, 2'b00, 1'b1, 4'd0);
    req = 2'b00;
    step();
    chk_all("t3_cancel", 2'b00, 2'b00, 1'b0, 4'd0);

    // T4a len1=0: one RUN cycle then done
    req  = 2'b10;
    len1 = 4'd0;
    step();
    chk_all("t4_len0_run", 2'b10, 2'b00, 1'b1, 4'd0);
    step();
    chk_all("t4_len0_done", 2'b00, 2'b10, 1'b1, 4'd0);
    req = 2'b00;
    step();
    chk_all("t4_len0_idle", 2'b00, 2'b00, 1'b0, 4'd0);

    // T4b len0=15: full count without wrap; mid-run len0 change ignored
    req  = 2'b01;
    len0 = 4'd15;
    step();
    chk_all("t4_full_q0", 2'b01, 2'b00, 1'b1, 4'd0);
    len0 = 4'd2;
    for (int k = 1; k < 16; k++) begin
      step();
      chk_all("t4_full_run", 2'b01, 2'b00, 1'b1, 4'(k));
    end
    step();
    chk_all("t4_full_done", 2'b00, 2'b01, 1'b1, 4'd15);
    req = 2'b00;
    step();
    chk_all("t4_full_idle", 2'b00, 2'b00, 1'b0, 4'd15);

    // T5 cancel at q=4, then requester 1 wins the tie
    req  = 2'b01;
    len0 = 4'd8;
    for (int k = 0; k < 5; k++) step();
    chk_all("t5_q4", 2'b01, 2'b00, 1'b1, 4'd4);
    req = 2'b00;
    step();
    chk_all("t5_dropped", 2'b00, 2'b00, 1'b0, 4'd4);
    step();
    chk_all("t5_hold", 2'b00, 2'b00, 1'b0, 4'd4);
    req  = 2'b11;
    len1 = 4'd8;
    step();
    chk_all("t5_next_g1", 2'b10, 2'b00, 1'b1, 4'd0);

    // T6 reset at q=5 mid-run; requester 0 then wins the tie
    for (int k = 0; k < 5; k++) step();
    chk_all("t6_q5", 2'b10, 2'b00, 1'b1, 4'd5);
    rst_n = 1'b0;
    step();
    chk_all("t6_reset", 2'b00, 2'b00, 1'b0, 4'd0);
    rst_n = 1'b1;
    step();
    chk_all("t6_tie_g0", 2'b01, 2'b00, 1'b1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
